// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, owner encoding, default widths.
// No logic of its own; imported by the interface, the round-robin picker and the top.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter; slave = arbiter view, master = core/memory view.
// Requests are level-held until the one-cycle ack; no other backpressure exists on this bundle.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_address, mem_data_in, mem_we, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_address, mem_data_in, mem_we, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick between instruction and data requests.
// Zero latency; on a tie the port opposite the last grant wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   i_instr_req,
    input  logic   i_data_req,
    input  owner_e i_last_grant,
    output logic   o_gnt_vld,
    output owner_e o_gnt_owner
);

    always_comb begin
        o_gnt_vld   = i_instr_req | i_data_req;
        o_gnt_owner = OWN_INSTR;
        if (i_instr_req && i_data_req) begin
            o_gnt_owner = (i_last_grant == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        end else if (i_data_req) begin
            o_gnt_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter serialising I-fetch and load/store onto one combinational-read memory.
// Grant->ack 2 cycles, one access per 3 cycles, requests held while busy; MEM_ARB_ALIGN_CHECK_EN flags misaligned accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    owner_e            r_owner;
    owner_e            r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data_in;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_gnt_vld;
    owner_e            w_gnt_owner;
    logic              w_grant;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_misalign;
    logic [DATA_W-1:0] w_rdata_cap;

    rr_arbiter2 u_rr (
        .i_instr_req  (bus.i_req),
        .i_data_req   (bus.d_req),
        .i_last_grant (r_last_grant),
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt_owner  (w_gnt_owner)
    );

    assign w_gnt_addr = (w_gnt_owner == OWN_DATA) ? bus.d_addr : bus.i_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_INSTR;
            r_last_grant  <= OWN_DATA;
            r_we          <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner       <= w_gnt_owner;
                r_last_grant  <= w_gnt_owner;
                r_mem_address <= w_gnt_addr;
                if (w_gnt_owner == OWN_DATA) begin
                    r_mem_data_in <= bus.d_wdata;
                    r_we          <= bus.d_we & ~w_misalign;
                end else begin
                    r_we <= 1'b0;
                end
            end
            // Stores capture the pre-write word: the memory updates at the end of this cycle.
            if (r_state == ST_ACCESS) begin
                if (r_owner == OWN_INSTR) begin
                    r_i_rdata <= w_rdata_cap;
                end else begin
                    r_d_rdata <= w_rdata_cap;
                end
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic r_misalign;
    logic r_i_err;
    logic r_d_err;

    assign w_misalign  = is_misaligned(w_gnt_addr[1:0]);
    assign w_rdata_cap = r_misalign ? '0 : bus.mem_data_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_misalign <= w_misalign;
            end
            if (r_state == ST_ACCESS) begin
                if (r_owner == OWN_INSTR) begin
                    r_i_err <= r_misalign;
                end else begin
                    r_d_err <= r_misalign;
                end
            end
        end
    end

    assign bus.i_err = r_i_err;
    assign bus.d_err = r_d_err;
`else
    assign w_misalign  = 1'b0;
    assign w_rdata_cap = bus.mem_data_out;
    assign bus.i_err   = 1'b0;
    assign bus.d_err   = 1'b0;
`endif

    // Reset masks the write strobe so an aborted store never reaches memory.
    assign bus.mem_we      = (r_state == ST_ACCESS) & r_we & ~reset;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.i_ack       = (r_state == ST_DONE) && (r_owner == OWN_INSTR);
    assign bus.d_ack       = (r_state == ST_DONE) && (r_owner == OWN_DATA);
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared single-port, combinational-read 32-bit main memory.
- Requesters:
  - instruction-fetch port (read-only);
  - data load/store port (read/write).
- Serialises accesses, drives the memory address/data/write-enable lines, captures read data and returns a one-cycle acknowledge to the winning requester.
- Sits between the processor core and the memory block.

Parameters:
ADDR_W, 32, byte-address width on all address ports
DATA_W, 32, data word width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  instruction port request; held high until i_ack
i_addr  input  ADDR_W  instruction byte address
i_ack  output  1  one-cycle pulse: instruction access complete
i_rdata  output  DATA_W  instruction read data, valid with i_ack, held until next i_ack
i_err  output  1  misaligned access flag, valid with i_ack
d_req  input  1  data port request; held high until d_ack
d_we  input  1  1 = store, 0 = load; sampled at grant
d_addr  input  ADDR_W  data byte address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle pulse: data access complete
d_rdata  output  DATA_W  load data, valid with d_ack, held until next d_ack
d_err  output  1  misaligned access flag, valid with d_ack
mem_address  output  ADDR_W  byte address to memory
mem_data_in  output  DATA_W  write data to memory
mem_we  output  1  memory write enable
mem_data_out  input  DATA_W  combinational read data from memory
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - all outputs 0;
  - FSM = IDLE;
  - last_grant = DATA, so the first tie goes to the instruction port.
- FSM states:
  - IDLE:
    - Only i_req: grant instruction port.
    - Only d_req: grant data port.
    - Both: grant the port opposite last_grant (round-robin).
    - On grant:
      - latch the address into mem_address;
      - latch d_wdata into mem_data_in and d_we into we_q (data port only; instruction grant forces we_q = 0);
      - set owner; update last_grant; go to ACCESS.
    - No request: stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - mem_we = (state == ACCESS) & we_q & ~reset. This is the only cycle mem_we can be 1.
    - Capture mem_data_out into the owner's rdata register; on a store, capture the pre-write read value.
    - Go to DONE.
  - DONE (1 cycle):
    - Assert the owner's ack for exactly this cycle; the other port's ack stays 0.
    - Go to IDLE.
- Latency: request sampled in IDLE at edge N → ack high during cycle N+2. Peak throughput is one access per 3 cycles.
- Requests are sampled only in IDLE. A request dropped mid-transaction still completes and still receives its ack.
- A requester holding req high through its ack cycle is re-eligible in the next IDLE. Round-robin still alternates when both are continuously requesting: I, D, I, D…
- mem_address and mem_data_in hold their latched values until the next grant.
- Reset mid-operation: the FSM returns to IDLE on the next edge. An in-flight store whose ACCESS cycle coincides with reset is not written (mem_we masked). No ack is issued for the aborted access.
- Widths: addresses pass through unmodified (byte address); no arithmetic on the data path.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN
- Defined:
  - A grant with addr[1:0] != 0 is flagged misaligned; we_q is forced to 0, so no memory write occurs.
  - The normal 3-cycle sequence runs; the owner's rdata is loaded with 0 and err = 1 with the ack.
  - Aligned accesses complete with err = 0.
- Undefined: i_err and d_err tied to 0; addr[1:0] forwarded untouched and not checked.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encoding (IDLE, ACCESS, DONE);
  - owner encoding (OWN_INSTR = 0, OWN_DATA = 1);
  - default ADDR_W / DATA_W constants.
- One natural sub-module, rr_arbiter2: combinational 2-way round-robin pick from {i_req, d_req, last_grant}. Everything else lives in mem_arbiter.

Test Plan:
- Reset then i_req = 1, i_addr = 0x10, memory word 4 = 0xDEADBEEF → i_ack pulses exactly 2 cycles after the request edge, i_rdata = 0xDEADBEEF, mem_we never 1.
- d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0x12345678 → mem_we high exactly one cycle with mem_address = 0x20; a following load from 0x20 returns 0x12345678 on d_rdata.
- i_req and d_req both held high for 12 cycles, from reset → acks alternate I, D, I, D (first ack i_ack); 4 acks total; ack spacing 3 cycles.
- Store to 0x30 granted, reset asserted during the ACCESS cycle → mem_we stays 0, word at 0x30 unchanged, no d_ack, busy = 0 after the reset edge.
- d_req pulsed high for 1 cycle only (load 0x40) → d_ack still issued 2 cycles later with the correct data.
- With MEM_ARB_ALIGN_CHECK_EN: store to 0x42 → no mem_we, d_ack with d_err = 1, d_rdata = 0. Without the macro: i_err and d_err remain 0 throughout.
